// File: rtl/adc_pkg.sv
// Shared types for the ADC capture path: IQ sample layout and capture FSM states.
package adc_pkg;

  localparam int IQ_W = 16;

  // I occupies the upper half of the stream word, Q the lower half.
  typedef struct packed {
    logic signed [IQ_W-1:0] i;
    logic signed [IQ_W-1:0] q;
  } iq_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/adc_axis_capture_if.sv
// ADC stream input plus FIFO readout bus; slave is the capture block, master the surrounding logic.
interface adc_axis_capture_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [DATA_W-1:0] m_iq_sample;
  logic              m_valid_iq;
  logic              m_ready;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_ready,
    input  s_axis_tready, m_iq_sample, m_valid_iq
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_ready,
    output s_axis_tready, m_iq_sample, m_valid_iq
  );

endinterface

// File: rtl/adc_sample_fifo.sv
// First-word-fall-through sample FIFO: a write at edge N is visible at the head after edge N.
// Writes when full and reads when empty are ignored; the head reads as zero while empty.
module adc_sample_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_rdy,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_dat,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic              push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push   = wr_vld && !full;
  assign pop    = rd_rdy && !empty;
  assign rd_vld = !empty;
  assign rd_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_dat;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/adc_axis_capture.sv
// ADC stream capture: start arms a cap_len window written into an FWFT FIFO (1-cycle latency); tlast ends it early.
// tready = !full in CAPTURE (a stalled beat sets sticky overflow), 1 elsewhere (beats dropped); ADC_ACCUM_EN adds I/Q sums.
module adc_axis_capture
  import adc_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16,
  parameter int ACC_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  adc_axis_capture_if.slave       axis,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cap_len,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [LEN_W-1:0]        captured_count
`ifdef ADC_ACCUM_EN
  ,
  output logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] acc_q
`endif
);

  if (ACC_W < IQ_W) begin : g_acc_w_check
    $error("ACC_W must be at least IQ_W");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  cap_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] count_inc;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             fifo_full, fifo_empty;
  logic             tready;
  logic             wr_en;
  logic             arm;

  assign tready    = (state_q == CAPTURE) ? !fifo_full : 1'b1;
  assign wr_en     = (state_q == CAPTURE) && axis.s_axis_tvalid && tready;
  assign arm       = start && (state_q != CAPTURE);
  assign count_inc = (&count_q) ? count_q : count_q + LEN_W'(1);

  assign axis.s_axis_tready = tready;
  assign busy               = (state_q == CAPTURE);
  assign done               = done_q;
  assign overflow           = ovf_q;
  assign captured_count     = count_q;

  adc_sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (wr_en),
    .wr_dat (axis.s_axis_tdata),
    .rd_rdy (axis.m_ready),
    .rd_vld (axis.m_valid_iq),
    .rd_dat (axis.m_iq_sample),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d   = cap_len;
          count_d = '0;
          ovf_d   = 1'b0;
          if (cap_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        // The ADC cannot be stalled, so a beat offered while full is lost.
        if (axis.s_axis_tvalid && fifo_full) begin
          ovf_d = 1'b1;
        end
        if (wr_en) begin
          count_d = count_inc;
          if ((count_inc == len_q) || axis.s_axis_tlast) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

`ifdef ADC_ACCUM_EN
  iq_t                    sample;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0] acc_q_q, acc_q_d;

  assign sample = iq_t'(axis.s_axis_tdata);
  assign acc_i  = acc_i_q;
  assign acc_q  = acc_q_q;

  // Sums wrap modulo 2^ACC_W and hold after the window until the next arm.
  always_comb begin
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    if (arm) begin
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (wr_en) begin
      acc_i_d = acc_i_q + ACC_W'(sample.i);
      acc_q_d = acc_q_q + ACC_W'(sample.q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else begin
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
    end
  end
`endif

endmodule

// File: tb/tb_adc_axis_capture.sv
// Randomised bench for adc_axis_capture: a window-level reference model predicts status and FIFO contents.
module tb_adc_axis_capture;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = 16;
  localparam int ACC_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  cap_len;
  logic              busy, done, overflow;
  logic [LEN_W-1:0]  captured_count;
`ifdef ADC_ACCUM_EN
  logic [ACC_W-1:0]  acc_i, acc_q;
`endif

  always #5 clk = ~clk;

  adc_axis_capture_if #(.DATA_W(DATA_W)) bus ();

  adc_axis_capture #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LEN_W),
    .ACC_W      (ACC_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .axis           (bus),
    .start          (start),
    .cap_len        (cap_len),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .captured_count (captured_count)
`ifdef ADC_ACCUM_EN
    ,
    .acc_i          (acc_i),
    .acc_q          (acc_q)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: window mode (0 idle, 1 capturing, 2 done), counts and the expected FIFO contents.
  logic [31:0] exp_q[$];
  int          mst, mlen, mcnt, mocc;
  bit          movf, mdone;
  logic [31:0] macc_i, macc_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mst = 0; mlen = 0; mcnt = 0; mocc = 0;
    movf = 0; mdone = 0; macc_i = 0; macc_q = 0;
    exp_q.delete();
  endfunction

  // One clock: apply inputs, check outputs at the falling edge, advance the model at the rising edge.
  task automatic cyc(input bit st, input int ln, input bit v, input logic [31:0] d,
                     input bit l, input bit r);
    bit full, rdy, acc, pop;
    logic [31:0] lnv;
    lnv = ln;
    start = st; cap_len = lnv[15:0];
    bus.s_axis_tvalid = v; bus.s_axis_tdata = d; bus.s_axis_tlast = l; bus.m_ready = r;
    @(negedge clk);
    chk("tready", bus.s_axis_tready, (mst == 1) ? (mocc != DEPTH) : 1'b1);
    chk("busy", busy, mst == 1);
    chk("done", done, mdone);
    chk("count", captured_count, mcnt);
    chk("overflow", overflow, movf);
    chk("m_valid", bus.m_valid_iq, mocc != 0);
`ifdef ADC_ACCUM_EN
    chk("acc_i", acc_i, macc_i);
    chk("acc_q", acc_q, macc_q);
`endif
    @(posedge clk);
    full = (mocc == DEPTH);
    rdy  = (mst != 1) || !full;
    acc  = v && rdy;
    pop  = (mocc != 0) && r;
    mdone = 0;
    if (mst != 1) begin
      if (st) begin
        mlen = lnv[15:0]; mcnt = 0; movf = 0; macc_i = 0; macc_q = 0;
        if (mlen == 0) begin mst = 2; mdone = 1; end
        else mst = 1;
      end
    end else begin
      if (v && full) movf = 1;
      if (acc) begin
        exp_q.push_back(d);
        mocc++;
        if (mcnt < 65535) mcnt++;
        macc_i += {{16{d[31]}}, d[31:16]};
        macc_q += {{16{d[15]}}, d[15:0]};
        if (mcnt == mlen || l) begin mst = 2; mdone = 1; end
      end
    end
    if (pop) mocc--;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", captured_count, 0);
    chk("rst_valid", bus.m_valid_iq, 0);
    chk("rst_sample", bus.m_iq_sample, 0);
    chk("rst_tready", bus.s_axis_tready, 1);
`ifdef ADC_ACCUM_EN
    chk("rst_acc_i", acc_i, 0);
    chk("rst_acc_q", acc_q, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Scoreboard monitor: every popped head must be the oldest expected sample.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.m_valid_iq === 1'b1 && bus.m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underflow: got sample %0h expected none", bus.m_iq_sample);
        end else begin
          chk("sample", bus.m_iq_sample, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int pv, pr;
    start = 0; cap_len = 0;
    bus.s_axis_tvalid = 0; bus.s_axis_tdata = 0; bus.s_axis_tlast = 0; bus.m_ready = 0;
    do_reset();

    // Beats while idle are dropped; then a 4-sample window read out in order.
    repeat (3) cyc(0, 0, 1, $urandom, 0, 1);
    cyc(1, 4, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 32'h0001_0002 + k * 32'h0001_0001, 0, 1);
    chk("len4_count", captured_count, 4);
    chk("len4_ovf", overflow, 0);

    // Stalled consumer: FIFO fills at 16, further beats are lost, then readout resumes.
    cyc(1, 32, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 1, $urandom, 0, 0);
    chk("stall_count", captured_count, 16);
    chk("stall_ovf", overflow, 1);
    chk("stall_tready", bus.s_axis_tready, 0);
    repeat (40) cyc(0, 0, 1, $urandom, 0, 1);
    chk("stall_final", captured_count, 32);

    // tlast on the third beat closes a 10-sample window early.
    cyc(1, 10, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, $urandom, k == 2, 1);
    chk("tlast_count", captured_count, 3);

    // Zero length completes immediately and captures nothing.
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, $urandom, 0, 1);
    repeat (3) cyc(0, 0, 1, $urandom, 0, 1);
    chk("len0_empty", bus.m_valid_iq, 0);

    // Reset in the middle of a window.
    cyc(1, 20, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, $urandom, 0, 0);
    do_reset();
    repeat (3) cyc(0, 0, 0, 0, 0, 1);

`ifdef ADC_ACCUM_EN
    cyc(1, 2, 0, 0, 0, 1);
    cyc(0, 0, 1, {16'hFFFD, 16'h0007}, 0, 1);
    cyc(0, 0, 1, {16'h0005, 16'hFFF6}, 0, 1);
    chk("acc_done", done, 1);
    chk("acc_i_sum", acc_i, 32'd2);
    chk("acc_q_sum", acc_q, 32'hFFFF_FFFD);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
`endif

    // Random windows, traffic and consumer pressure, with stray starts.
    for (int w = 0; w < 15; w++) begin
      pv = $urandom_range(30, 100);
      pr = $urandom_range(0, 100);
      cyc(1, $urandom_range(0, 40), 0, 0, 0, 1);
      repeat (60) cyc(($urandom % 50) == 0, $urandom_range(0, 40), ($urandom % 100) < pv,
                      $urandom, ($urandom % 100) < 3, ($urandom % 100) < pr);
    end

    repeat (20) cyc(0, 0, 0, 0, 0, 1);
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
